// File: rtl/equiv_stim_checker.sv
// equiv_stim_checker: drives LFSR vectors into two DUTs, compares their responses and signs both streams
module equiv_stim_checker #(
  parameter int IN_W = 83,
  parameter int OUT_W = 245,
  parameter int NUM_VEC = 32,
  parameter int LATENCY = 1,
  parameter int ZERO_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [15:0]      first_fail_idx,
  output logic [15:0]      vec_cnt,
  output logic [31:0]      sig_ref,
  output logic [31:0]      sig_dut
);
  localparam int NS = (OUT_W + 31) / 32;
  localparam logic [15:0] LAST = 16'(NUM_VEC - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] lfsr, fold_ref, fold_dut;
  logic [15:0] idx, cmp_idx;
  logic [3:0] drain_cnt;
  logic cmp_v, cmp_ok;
  logic [IN_W-1:0] rep;
  logic [NS*32-1:0] ref_pad, dut_pad;

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  for (genvar i = 0; i < IN_W; i++) begin : g_rep
    assign rep[i] = lfsr[i % 32];
  end

  // each applied vector carries its index down a LATENCY-deep line so it meets its response
  if (LATENCY == 0) begin : g_nopipe
    assign cmp_v = state == RUN;
    assign cmp_idx = idx;
  end else begin : g_pipe
    logic [LATENCY-1:0] v_q;
    logic [15:0] i_q [LATENCY];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= '0;
        for (int j = 0; j < LATENCY; j++) i_q[j] <= '0;
      end else begin
        v_q[0] <= state == RUN;
        i_q[0] <= idx;
        for (int j = 1; j < LATENCY; j++) begin
          v_q[j] <= v_q[j-1];
          i_q[j] <= i_q[j-1];
        end
      end
    assign cmp_v = v_q[LATENCY-1];
    assign cmp_idx = i_q[LATENCY-1];
  end

  assign cmp_ok = cmp_v && (state == RUN || state == DRAIN);
  assign stim = (state == RUN && !(ZERO_MODE == 1 && idx[0])) ? rep : '0;
  assign busy = state == LOAD || state == RUN || state == DRAIN;
  assign done = state == DONE;

  always_comb begin
    ref_pad = '0;
    dut_pad = '0;
    ref_pad[OUT_W-1:0] = y_ref;
    dut_pad[OUT_W-1:0] = y_dut;
    fold_ref = '0;
    fold_dut = '0;
    for (int j = 0; j < NS; j++) begin
      fold_ref ^= ref_pad[j*32 +: 32];
      fold_dut ^= dut_pad[j*32 +: 32];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? LOAD : state;
      LOAD:       state_n = RUN;
      RUN:        state_n = idx != LAST ? RUN : (LATENCY == 0 ? DONE : DRAIN);
      DRAIN:      state_n = drain_cnt == 4'(LATENCY - 1) ? DONE : DRAIN;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lfsr <= 32'h1;
      idx <= '0;
      drain_cnt <= '0;
      vec_cnt <= '0;
      mismatch <= 1'b0;
      first_fail_idx <= '0;
      sig_ref <= '0;
      sig_dut <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD) begin
        lfsr <= seed == 32'h0 ? 32'h1 : seed;
        idx <= '0;
        drain_cnt <= '0;
        vec_cnt <= '0;
        mismatch <= 1'b0;
        first_fail_idx <= '0;
        sig_ref <= '0;
        sig_dut <= '0;
      end else begin
        if (state == RUN) begin
          lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
          idx <= idx + 16'd1;
        end
        if (state == DRAIN) drain_cnt <= drain_cnt + 4'd1;
        if (cmp_ok) begin
          vec_cnt <= vec_cnt + 16'd1;
          sig_ref <= sig_step(sig_ref, fold_ref);
          sig_dut <= sig_step(sig_dut, fold_dut);
          if (y_ref != y_dut) begin
            mismatch <= 1'b1;
            if (!mismatch) first_fail_idx <= cmp_idx;
          end
        end
      end
    end
endmodule

// File: tb/tb_equiv_stim_checker.sv
// tb_equiv_stim_checker: table, random and hand-sequenced checks of equiv_stim_checker against a spec-level model
module tb_equiv_stim_checker;
  localparam int M_IN = 83, M_OUT = 245, NV = 8, LAT = 1;
  typedef struct {
    logic [31:0] seed;
    logic [7:0]  fm;
    bit          sp;
    logic        mm;
    logic [15:0] ffi;
  } vec_t;

  logic clk = 0, rst_n = 0, start = 0, e_start = 0;
  logic [31:0] seed = 0, e_seed = 0;
  logic [M_IN-1:0] stim;
  logic [M_OUT-1:0] y_ref = '0, y_dut = '0;
  logic busy, done, mismatch;
  logic [15:0] first_fail_idx, vec_cnt;
  logic [31:0] sig_ref, sig_dut;
  logic [7:0] e_stim;
  logic [39:0] e_y_ref = '0, e_y_dut = '0;
  logic e_busy, e_done, e_mismatch;
  logic [15:0] e_ffi, e_vec_cnt;
  logic [31:0] e_sig_ref, e_sig_dut;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  equiv_stim_checker #(.IN_W(M_IN), .OUT_W(M_OUT), .NUM_VEC(NV), .LATENCY(LAT), .ZERO_MODE(1)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .stim(stim), .y_ref(y_ref), .y_dut(y_dut),
    .busy(busy), .done(done), .mismatch(mismatch), .first_fail_idx(first_fail_idx), .vec_cnt(vec_cnt),
    .sig_ref(sig_ref), .sig_dut(sig_dut));

  equiv_stim_checker #(.IN_W(8), .OUT_W(40), .NUM_VEC(1), .LATENCY(0), .ZERO_MODE(1)) u_edge (
    .clk(clk), .rst_n(rst_n), .start(e_start), .seed(e_seed), .stim(e_stim), .y_ref(e_y_ref), .y_dut(e_y_dut),
    .busy(e_busy), .done(e_done), .mismatch(e_mismatch), .first_fail_idx(e_ffi), .vec_cnt(e_vec_cnt),
    .sig_ref(e_sig_ref), .sig_dut(e_sig_dut));

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [M_IN-1:0] rep(input logic [31:0] l);
    logic [M_IN-1:0] r;
    for (int i = 0; i < M_IN; i++) r[i] = l[i % 32];
    return r;
  endfunction

  function automatic logic [31:0] fold(input logic [1023:0] p);
    logic [31:0] f = '0;
    for (int i = 0; i < 32; i++) f ^= p[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [31:0] crc_next(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [M_OUT-1:0] rnd_out();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[M_OUT-1:0];
  endfunction

  // one full run on u_main; y for vector k is presented LAT cycles after it was applied, garbage otherwise
  task automatic run_main(input logic [31:0] sd, input logic [7:0] fm, input bit rnd_y, input bit sp,
                          input logic exp_mm, input logic [15:0] exp_ffi, input string tag,
                          output logic [31:0] sref_o);
    logic [31:0] l, esr, esd;
    logic [M_IN-1:0] ev [NV];
    logic [M_IN-1:0] es;
    logic [M_OUT-1:0] yr [NV];
    logic [M_OUT-1:0] yd [NV];
    int c, k;
    l = sd == 32'h0 ? 32'h1 : sd;
    esr = '0;
    esd = '0;
    for (int v = 0; v < NV; v++) begin
      ev[v] = (v % 2 == 1) ? '0 : rep(l);
      l = lfsr_next(l);
      yr[v] = rnd_y ? rnd_out() : M_OUT'(ev[v]);
      yd[v] = yr[v] ^ M_OUT'(fm[v]);
      esr = crc_next(esr, fold(1024'(yr[v])));
      esd = crc_next(esd, fold(1024'(yd[v])));
    end
    @(negedge clk);
    seed = sd;
    start = 1;
    @(posedge clk); #1;
    c = 0;
    while (!done && c < 100) begin
      if (c == 1) chk({tag, " cleared"}, 1024'({vec_cnt, mismatch, first_fail_idx, sig_ref, sig_dut}), 1024'(0));
      chk({tag, " busy"}, 1024'(busy), 1024'(1));
      @(negedge clk);
      start = sp && (c == 2 || c == NV + 1);
      es = '0;
      if (c >= 1 && c <= NV) es = ev[c-1];
      chk($sformatf("%s stim c%0d", tag, c), 1024'(stim), 1024'(es));
      k = c - 1 - LAT;
      if (k >= 0 && k < NV) begin
        y_ref = yr[k];
        y_dut = yd[k];
      end else begin
        y_ref = rnd_out();
        y_dut = rnd_out();
      end
      @(posedge clk); #1;
      c++;
    end
    start = 0;
    chk({tag, " latency"}, 1024'(c + 1), 1024'(NV + LAT + 2));
    chk({tag, " vec_cnt"}, 1024'(vec_cnt), 1024'(NV));
    chk({tag, " mismatch"}, 1024'(mismatch), 1024'(exp_mm));
    chk({tag, " first_fail_idx"}, 1024'(first_fail_idx), 1024'(exp_ffi));
    chk({tag, " sig_ref"}, 1024'(sig_ref), 1024'(esr));
    chk({tag, " sig_dut"}, 1024'(sig_dut), 1024'(esd));
    chk({tag, " idle outputs"}, 1024'({busy, stim}), 1024'(0));
    repeat (2) begin
      @(negedge clk);
      y_ref = rnd_out();
      y_dut = rnd_out();
      @(posedge clk); #1;
    end
    chk({tag, " hold"}, 1024'({done, vec_cnt, mismatch, first_fail_idx, sig_ref, sig_dut}),
        1024'({1'b1, 16'(NV), exp_mm, exp_ffi, esr, esd}));
    sref_o = esr;
  endtask

  initial begin
    vec_t tbl [5];
    logic [31:0] clean_sig, s, sd;
    logic [7:0] fm;
    logic [15:0] ffi;
    tbl[0] = '{32'h1,        8'h00, 0, 1'b0, 16'd0};
    tbl[1] = '{32'h1,        8'h60, 0, 1'b1, 16'd5};
    tbl[2] = '{32'h0,        8'h00, 0, 1'b0, 16'd0};
    tbl[3] = '{32'hDEADBEEF, 8'h81, 1, 1'b1, 16'd0};
    tbl[4] = '{32'h12345678, 8'h80, 1, 1'b1, 16'd7};
    clean_sig = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset main", 1024'({stim, busy, done, mismatch, first_fail_idx, vec_cnt, sig_ref, sig_dut}), 1024'(0));
    chk("reset edge", 1024'({e_stim, e_busy, e_done, e_mismatch, e_ffi, e_vec_cnt, e_sig_ref, e_sig_dut}), 1024'(0));
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      run_main(tbl[i].seed, tbl[i].fm, 0, tbl[i].sp, tbl[i].mm, tbl[i].ffi, $sformatf("tbl%0d", i), s);
      if (i == 0) clean_sig = s;
      if (tbl[i].seed == 32'h0) chk("seed0 sig_ref", 1024'(sig_ref), 1024'(clean_sig));
    end
    for (int r = 0; r < 6; r++) begin
      sd = $urandom;
      fm = 8'($urandom);
      ffi = '0;
      for (int k = NV - 1; k >= 0; k--) if (fm[k]) ffi = 16'(k);
      run_main(sd, fm, 1, r[0], |fm, ffi, $sformatf("rnd%0d", r), s);
    end
    // reset while vector 3 is on stim, then restart with the clean-run seed
    @(negedge clk);
    seed = 32'h1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun busy", 1024'(busy), 1024'(1));
    rst_n = 0;
    #1;
    chk("midrun reset", 1024'({stim, busy, done, mismatch, first_fail_idx, vec_cnt, sig_ref, sig_dut}), 1024'(0));
    @(posedge clk); #1;
    chk("midrun idle", 1024'({busy, done}), 1024'(0));
    rst_n = 1;
    run_main(32'h1, 8'h00, 0, 0, 1'b0, 16'd0, "restart", s);
    chk("restart sig_ref", 1024'(sig_ref), 1024'(clean_sig));
    // NUM_VEC=1, LATENCY=0 instance
    @(negedge clk);
    e_seed = 32'hA5C30F1E;
    e_start = 1;
    e_y_ref = 40'h1;
    e_y_dut = 40'h2;
    @(posedge clk); #1;
    chk("edge load", 1024'({e_busy, e_done, e_stim}), 1024'({1'b1, 1'b0, 8'h0}));
    @(negedge clk);
    e_start = 0;
    e_y_ref = 40'hF012345678;
    e_y_dut = 40'hF012345679;
    @(posedge clk); #1;
    chk("edge run", 1024'({e_busy, e_done, e_stim}), 1024'({1'b1, 1'b0, 8'h1E}));
    @(posedge clk); #1;
    chk("edge done", 1024'({e_busy, e_done, e_stim}), 1024'({1'b0, 1'b1, 8'h0}));
    chk("edge result", 1024'({e_vec_cnt, e_mismatch, e_ffi, e_sig_ref, e_sig_dut}),
        1024'({16'd1, 1'b1, 16'd0, 32'h12345688, 32'h12345689}));
    @(negedge clk);
    e_y_dut = 40'hFF;
    @(posedge clk); #1;
    chk("edge hold", 1024'({e_done, e_vec_cnt, e_sig_ref}), 1024'({1'b1, 16'd1, 32'h12345688}));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
